fetch_unit: RTL and testbench

//  - Instruction fetch stage feeding the CPU controller: owns the program counter, requests words from

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory req/ack fetch, instruction register.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 23,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               inc_pc,
  input  logic               branch,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] code,
  output logic               ir_valid,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  state_t state;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wdog;
`else
  // No watchdog: the error flag can never be raised.
  assign fetch_err = (TIMEOUT < 0);
`endif

  assign mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RST_PC;
      code      <= '0;
      ir_valid  <= 1'b0;
      mem_req   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
      wdog      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pc      <= RST_PC;
            mem_req <= 1'b1;
            state   <= FETCH;
`ifdef FETCH_TIMEOUT_EN
            wdog    <= '0;
`endif
          end
        end
        FETCH: begin
          if (mem_ack) begin
            code     <= mem_rdata;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wdog == WD_LAST) begin
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (branch || inc_pc) begin
            // branch has priority over inc_pc
            pc       <= branch ? code[PC_W-1:0] : pc + 1'b1;
            ir_valid <= 1'b0;
            mem_req  <= 1'b1;
            state    <= FETCH;
`ifdef FETCH_TIMEOUT_EN
            wdog     <= '0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, hand sequences,
// and randomized traffic against a transaction-level model.
module tb_fetch_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 23;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               inc_pc;
  logic               branch;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] code;
  logic               ir_valid;
  logic [PC_W-1:0]    pc;
  logic               fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .PC_W(PC_W),
    .INSTR_W(INSTR_W),
    .RESET_PC(0),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .inc_pc(inc_pc),
    .branch(branch),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .code(code),
    .ir_valid(ir_valid),
    .pc(pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Model: idle / fetching (outstanding request) / holding a word.
  bit                 m_idle;
  bit                 m_req;
  bit                 m_valid;
  bit                 m_err;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_code;
  int                 m_wait;

  typedef struct {
    bit                 s;
    bit                 i;
    bit                 b;
    bit                 a;
    logic [INSTR_W-1:0] d;
    bit                 e_req;
    logic [PC_W-1:0]    e_addr;
    bit                 e_valid;
    logic [INSTR_W-1:0] e_code;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1;
    m_req   = 0;
    m_valid = 0;
    m_err   = 0;
    m_pc    = '0;
    m_code  = '0;
    m_wait  = 0;
  endtask

  task automatic model_step();
    if (m_idle) begin
      if (start) begin
        m_idle = 0;
        m_req  = 1;
        m_pc   = '0;
        m_wait = 0;
      end
    end else if (m_req) begin
      if (mem_ack) begin
        m_code  = mem_rdata;
        m_valid = 1;
        m_req   = 0;
      end else begin
        m_wait++;
`ifdef FETCH_TIMEOUT_EN
        if (m_wait == TIMEOUT) begin
          m_err  = 1;
          m_req  = 0;
          m_idle = 1;
        end
`endif
      end
    end else if (branch || inc_pc) begin
      m_pc    = branch ? m_code[PC_W-1:0] : m_pc + 8'd1;
      m_valid = 0;
      m_req   = 1;
      m_wait  = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".req"}, mem_req, m_req);
    chk({tag, ".addr"}, mem_addr, m_pc);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".valid"}, ir_valid, m_valid);
    chk({tag, ".code"}, code, m_code);
    chk({tag, ".err"}, fetch_err, m_err);
  endtask

  // Called at a negedge: drive, advance model, move to next negedge.
  task automatic cycle(input bit s, input bit i, input bit b,
                       input bit a, input logic [INSTR_W-1:0] d);
    start     = s;
    inc_pc    = i;
    branch    = b;
    mem_ack   = a;
    mem_rdata = d;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1;
    start     = 0;
    inc_pc    = 0;
    branch    = 0;
    mem_ack   = 0;
    mem_rdata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 23'h0,      1, 8'h00, 0, 23'h0};
    tbl[1]  = '{0, 0, 0, 1, 23'h100001, 0, 8'h00, 1, 23'h100001};
    tbl[2]  = '{0, 1, 0, 0, 23'h0,      1, 8'h01, 0, 23'h100001};
    tbl[3]  = '{0, 0, 0, 1, 23'h200002, 0, 8'h01, 1, 23'h200002};
    tbl[4]  = '{0, 1, 0, 0, 23'h0,      1, 8'h02, 0, 23'h200002};
    tbl[5]  = '{0, 0, 0, 1, 23'h50003C, 0, 8'h02, 1, 23'h50003C};
    tbl[6]  = '{0, 1, 1, 0, 23'h0,      1, 8'h3C, 0, 23'h50003C};
    tbl[7]  = '{0, 1, 0, 0, 23'h1234,   1, 8'h3C, 0, 23'h50003C};
    tbl[8]  = '{0, 1, 1, 0, 23'h0,      1, 8'h3C, 0, 23'h50003C};
    tbl[9]  = '{1, 0, 0, 0, 23'h0,      1, 8'h3C, 0, 23'h50003C};
    tbl[10] = '{0, 0, 0, 0, 23'h0,      1, 8'h3C, 0, 23'h50003C};
    tbl[11] = '{0, 1, 0, 0, 23'h0,      1, 8'h3C, 0, 23'h50003C};
    tbl[12] = '{0, 0, 0, 1, 23'h0000FF, 0, 8'h3C, 1, 23'h0000FF};
    tbl[13] = '{1, 0, 0, 0, 23'h0,      0, 8'h3C, 1, 23'h0000FF};
    tbl[14] = '{0, 0, 1, 0, 23'h0,      1, 8'hFF, 0, 23'h0000FF};
    tbl[15] = '{0, 0, 0, 1, 23'h7FFFFF, 0, 8'hFF, 1, 23'h7FFFFF};
    tbl[16] = '{0, 1, 0, 0, 23'h0,      1, 8'h00, 0, 23'h7FFFFF};

    do_reset();
    chk("rst.req", mem_req, 1'b0);
    chk("rst.addr", mem_addr, 8'h00);
    chk("rst.valid", ir_valid, 1'b0);
    chk("rst.code", code, 23'h0);
    chk("rst.err", fetch_err, 1'b0);

    // Idle ignores the controller
    cycle(0, 1, 1, 1, 23'h55);
    chk("idle.req", mem_req, 1'b0);
    chk("idle.valid", ir_valid, 1'b0);

    for (int k = 0; k < 17; k++) begin
      cycle(tbl[k].s, tbl[k].i, tbl[k].b, tbl[k].a, tbl[k].d);
      chk($sformatf("vec%0d.req", k), mem_req, tbl[k].e_req);
      chk($sformatf("vec%0d.addr", k), mem_addr, tbl[k].e_addr);
      chk($sformatf("vec%0d.valid", k), ir_valid, tbl[k].e_valid);
      chk($sformatf("vec%0d.code", k), code, tbl[k].e_code);
      chk($sformatf("vec%0d.err", k), fetch_err, 1'b0);
    end

    // Asynchronous reset mid-fetch, then a late ack
    #2 rst = 1;
    #1;
    chk("arst.req", mem_req, 1'b0);
    chk("arst.pc", pc, 8'h00);
    chk("arst.valid", ir_valid, 1'b0);
    chk("arst.code", code, 23'h0);
    model_reset();
    @(negedge clk);
    rst = 0;
    cycle(0, 0, 0, 1, 23'h123);
    chk("late_ack.valid", ir_valid, 1'b0);
    chk("late_ack.code", code, 23'h0);
    chk("late_ack.req", mem_req, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    cycle(1, 0, 0, 0, 23'h0);
    for (int k = 0; k < TIMEOUT - 1; k++) cycle(0, 0, 0, 0, 23'h0);
    chk("wd15.req", mem_req, 1'b1);
    chk("wd15.err", fetch_err, 1'b0);
    cycle(0, 0, 0, 0, 23'h0);
    chk("wd16.req", mem_req, 1'b0);
    chk("wd16.err", fetch_err, 1'b1);
    cycle(0, 1, 1, 0, 23'h0);
    chk("wd_idle.req", mem_req, 1'b0);
    chk("wd_idle.err", fetch_err, 1'b1);

    do_reset();
    cycle(1, 0, 0, 0, 23'h0);
    for (int k = 0; k < TIMEOUT - 1; k++) cycle(0, 0, 0, 0, 23'h0);
    cycle(0, 0, 0, 1, 23'h0ABCDE);
    chk("wd_ack.valid", ir_valid, 1'b1);
    chk("wd_ack.code", code, 23'h0ABCDE);
    chk("wd_ack.err", fetch_err, 1'b0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int bias;
      bias = ((n / 100) % 2 == 0) ? 4 : 1;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) < bias,
            INSTR_W'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
